// File: rtl/retire_trace_buffer_if.sv
// Retire-trace bus: retire stream in, trace drain out, plus status/statistics.
// master = core/consumer side, slave = the trace buffer.
interface retire_trace_buffer_if #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16,
  parameter int CNT_W = 32
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             retire_i;
  logic [31:0]      retire_instr_i;
  logic             clear_i;
  logic             out_valid_o;
  logic [31:0]      out_instr_o;
  logic [TS_W-1:0]  out_ts_o;
  logic             out_ready_i;
  logic [LVL_W-1:0] level_o;
  logic             full_o;
  logic             overflow_o;
  logic [CNT_W-1:0] retired_cnt_o;
  logic [CNT_W-1:0] dropped_cnt_o;

  modport master (
    output retire_i, retire_instr_i, clear_i, out_ready_i,
    input  out_valid_o, out_instr_o, out_ts_o, level_o, full_o, overflow_o,
           retired_cnt_o, dropped_cnt_o
  );

  modport slave (
    input  retire_i, retire_instr_i, clear_i, out_ready_i,
    output out_valid_o, out_instr_o, out_ts_o, level_o, full_o, overflow_o,
           retired_cnt_o, dropped_cnt_o
  );
endinterface

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: timestamps each retired instruction into a FWFT FIFO,
// drained over valid/ready. Retired/dropped counters make lost entries visible.
module retire_trace_buffer #(
  parameter int DEPTH      = 8,
  parameter int TS_W       = 16,
  parameter int CNT_W      = 32,
  parameter int FILTER_NOP = 0
) (
  input logic                  clock_i,
  input logic                  reset_i,
  retire_trace_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [TS_W-1:0] ts;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [LVL_W-1:0] level;
  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] retired_cnt, dropped_cnt;
  logic             overflow;

  logic push_req, empty, full, pop, do_push, drop;
  entry_t head;

  // Handshake decode: a push into a full FIFO survives only if the head
  // leaves in the same cycle; otherwise the beat is dropped.
  always_comb begin
    push_req = bus.retire_i && !((FILTER_NOP != 0) && (bus.retire_instr_i == 32'h0));
    empty    = (level == '0);
    full     = (level == LVL_W'(DEPTH));
    pop      = !empty && bus.out_ready_i;
    do_push  = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // Free-running cycle timestamp, wraps naturally at 2^TS_W.
  always_ff @(posedge clock_i) begin
    if (reset_i) ts <= '0;
    else         ts <= ts + TS_W'(1);
  end

  // Entry storage; not reset, validity is carried by level.
  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr] <= '{instr: bus.retire_instr_i, ts: ts};
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap for free.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Statistics: saturating counters and sticky overflow; clear beats a same-cycle beat.
  always_ff @(posedge clock_i) begin
    if (reset_i || bus.clear_i) begin
      retired_cnt <= '0;
      dropped_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      if (bus.retire_i && (retired_cnt != {CNT_W{1'b1}}))
        retired_cnt <= retired_cnt + CNT_W'(1);
      if (drop && (dropped_cnt != {CNT_W{1'b1}}))
        dropped_cnt <= dropped_cnt + CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // Head is read from registered storage only, so retire_i never reaches out_*.
  // Outputs are forced to zero while empty so reset/idle values are deterministic.
  always_comb begin
    head              = mem[rd_ptr];
    bus.out_valid_o   = !empty;
    bus.out_instr_o   = empty ? 32'h0 : head.instr;
    bus.out_ts_o      = empty ? '0 : head.ts;
    bus.level_o       = level;
    bus.full_o        = full;
    bus.overflow_o    = overflow;
    bus.retired_cnt_o = retired_cnt;
    bus.dropped_cnt_o = dropped_cnt;
  end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: two instances (FILTER_NOP 0 and 1) share one
// stimulus; a queue-based reference model is checked every cycle, plus directed
// scenario checks against constants.
module tb_retire_trace_buffer;
  localparam int DEPTH = 8;
  localparam int TS_W  = 16;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        retire = 1'b0;
  logic [31:0] instr = '0;
  logic        clr = 1'b0;
  logic        rdy = 1'b0;

  retire_trace_buffer_if #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) ifc0 ();
  retire_trace_buffer_if #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) ifc1 ();

  assign ifc0.retire_i = retire;  assign ifc1.retire_i = retire;
  assign ifc0.retire_instr_i = instr;  assign ifc1.retire_instr_i = instr;
  assign ifc0.clear_i = clr;  assign ifc1.clear_i = clr;
  assign ifc0.out_ready_i = rdy;  assign ifc1.out_ready_i = rdy;

  retire_trace_buffer #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W), .FILTER_NOP(0)) u0 (
    .clock_i(clk), .reset_i(rst), .bus(ifc0.slave));
  retire_trace_buffer #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W), .FILTER_NOP(1)) u1 (
    .clock_i(clk), .reset_i(rst), .bus(ifc1.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-instance queue of {instr, ts}, plain counters.
  logic [47:0] mq [2][$];
  int unsigned m_ts;
  longint      m_ret [2];
  longint      m_drp [2];
  bit          m_ovf [2];
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
        m_ret[k] = 0; m_drp[k] = 0; m_ovf[k] = 0;
      end else begin
        bit had_space, popped, want;
        had_space = mq[k].size() < DEPTH;
        popped    = (mq[k].size() > 0) && rdy;
        want      = retire && !(k == 1 && instr == 32'h0);
        if (popped) void'(mq[k].pop_front());
        if (want) begin
          if (had_space || popped) mq[k].push_back({instr, 16'(m_ts)});
          else if (!clr) begin
            if (m_drp[k] < CNT_MAX) m_drp[k]++;
            m_ovf[k] = 1;
          end
        end
        if (clr) begin
          m_ret[k] = 0; m_drp[k] = 0; m_ovf[k] = 0;
        end else if (retire && m_ret[k] < CNT_MAX) m_ret[k]++;
      end
    end
    m_ts = rst ? 0 : (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic check_dut(input int k, input logic ov, input logic [31:0] oi,
                           input logic [TS_W-1:0] ots, input logic [3:0] lvl,
                           input logic fl, input logic of, input logic [CNT_W-1:0] rc,
                           input logic [CNT_W-1:0] dc);
    logic [47:0] h;
    h = (mq[k].size() > 0) ? mq[k][0] : 48'h0;
    chk($sformatf("d%0d_valid", k), 64'(ov), 64'(mq[k].size() > 0));
    chk($sformatf("d%0d_instr", k), 64'(oi), 64'(h[47:16]));
    chk($sformatf("d%0d_ts", k), 64'(ots), 64'(h[15:0]));
    chk($sformatf("d%0d_level", k), 64'(lvl), 64'(mq[k].size()));
    chk($sformatf("d%0d_full", k), 64'(fl), 64'(mq[k].size() == DEPTH));
    chk($sformatf("d%0d_ovf", k), 64'(of), 64'(m_ovf[k]));
    chk($sformatf("d%0d_ret", k), 64'(rc), 64'(m_ret[k]));
    chk($sformatf("d%0d_drp", k), 64'(dc), 64'(m_drp[k]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_dut(0, ifc0.out_valid_o, ifc0.out_instr_o, ifc0.out_ts_o, ifc0.level_o,
              ifc0.full_o, ifc0.overflow_o, ifc0.retired_cnt_o, ifc0.dropped_cnt_o);
    check_dut(1, ifc1.out_valid_o, ifc1.out_instr_o, ifc1.out_ts_o, ifc1.level_o,
              ifc1.full_o, ifc1.overflow_o, ifc1.retired_cnt_o, ifc1.dropped_cnt_o);
  endtask

  task automatic do_reset();
    rst = 1'b1; retire = 1'b1; instr = 32'hDEAD_0001; clr = 1'b0;
    tick(); tick();
    rst = 1'b0; retire = 1'b0;
    chk("rst_level", 64'(ifc0.level_o), 64'd0);
    chk("rst_valid", 64'(ifc0.out_valid_o), 64'd0);
    chk("rst_ret", 64'(ifc0.retired_cnt_o), 64'd0);
  endtask

  logic [31:0] a [3];

  initial begin
    m_ts = 0;
    a[0] = 32'hA1A1_0001; a[1] = 32'hA2A2_0002; a[2] = 32'hA3A3_0003;

    // 1: ordered drain, timestamps 5,6,7
    do_reset();
    rdy = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      retire = 1'b1; instr = a[i];
      tick();
      chk("t1_instr", 64'(ifc0.out_instr_o), 64'(a[i]));
      chk("t1_ts", 64'(ifc0.out_ts_o), 64'(5 + i));
    end
    retire = 1'b0;
    tick();
    chk("t1_level", 64'(ifc0.level_o), 64'd0);
    chk("t1_ret", 64'(ifc0.retired_cnt_o), 64'd3);

    // 2: fill, then one dropped beat
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      retire = 1'b1; instr = 32'h100 + i;
      tick();
    end
    chk("t2_full", 64'(ifc0.full_o), 64'd1);
    chk("t2_level", 64'(ifc0.level_o), 64'd8);
    instr = 32'h999;
    tick();
    retire = 1'b0;
    tick();
    chk("t2_drp", 64'(ifc0.dropped_cnt_o), 64'd1);
    chk("t2_ovf", 64'(ifc0.overflow_o), 64'd1);
    chk("t2_ret", 64'(ifc0.retired_cnt_o), 64'd9);
    chk("t2_head", 64'(ifc0.out_instr_o), 64'h100);

    // 3: full with push+pop: no drop, new entry last
    retire = 1'b1; rdy = 1'b1; instr = 32'hBEEF;
    tick();
    retire = 1'b0;
    chk("t3_level", 64'(ifc0.level_o), 64'd8);
    chk("t3_drp", 64'(ifc0.dropped_cnt_o), 64'd1);
    repeat (7) tick();
    chk("t3_last", 64'(ifc0.out_instr_o), 64'hBEEF);
    tick();
    chk("t3_empty", 64'(ifc0.out_valid_o), 64'd0);

    // 4: NOP filter
    do_reset();
    rdy = 1'b0;
    retire = 1'b1; instr = 32'h0; tick();
    instr = 32'h0102_0304; tick();
    retire = 1'b0; tick();
    chk("t4_f_level", 64'(ifc1.level_o), 64'd1);
    chk("t4_f_instr", 64'(ifc1.out_instr_o), 64'h0102_0304);
    chk("t4_f_ret", 64'(ifc1.retired_cnt_o), 64'd2);
    chk("t4_nf_level", 64'(ifc0.level_o), 64'd2);

    // 5: timestamp wrap
    do_reset();
    rdy = 1'b0;
    repeat ((1 << TS_W) + 2) tick();
    retire = 1'b1; instr = 32'h5555; tick();
    retire = 1'b0;
    chk("t5_ts", 64'(ifc0.out_ts_o), 64'd2);

    // 6: reset with stored entries, then clear with a retire beat
    do_reset();
    rdy = 1'b0;
    retire = 1'b1;
    for (int i = 0; i < 5; i++) begin instr = 32'h600 + i; tick(); end
    rst = 1'b1; tick();
    rst = 1'b0; retire = 1'b0;
    chk("t6_level", 64'(ifc0.level_o), 64'd0);
    chk("t6_valid", 64'(ifc0.out_valid_o), 64'd0);
    chk("t6_ret", 64'(ifc0.retired_cnt_o), 64'd0);
    retire = 1'b1;
    for (int i = 0; i < 2; i++) begin instr = 32'h700 + i; tick(); end
    clr = 1'b1; instr = 32'h777; tick();
    clr = 1'b0; retire = 1'b0;
    chk("t6_clr_ret", 64'(ifc0.retired_cnt_o), 64'd0);
    chk("t6_clr_level", 64'(ifc0.level_o), 64'd3);

    // Random traffic with occasional clear/reset; ready bias varies by phase
    for (int i = 0; i < 4000; i++) begin
      int rbias;
      rbias  = ((i / 500) % 2 == 0) ? 30 : 80;
      retire = ($urandom_range(0, 99) < 60);
      instr  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      rdy    = ($urandom_range(0, 99) < rbias);
      clr    = ($urandom_range(0, 99) == 0);
      rst    = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; clr = 1'b0; retire = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
